// File: rtl/mips_control_fsm.sv
// mips_control_fsm
// Multi-cycle control sequencer for the MIPS datapath. Holds the fetched
// instruction in an internal IR, steps it through IF/ID/EX/MEM/WB and drives
// the ALU control word, register-file/memory/PC strobes and error pulses.
// stage, IR, the memory wait counter and the retired counter are registered;
// every other output is decoded combinationally from them (plus zero and
// mem_ready in the MEM stage).

module mips_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [31:0]            instr,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic [2:0]             stage,
    output logic [1:0]             alu_op,
    output logic [5:0]             alu_funct,
    output logic                   ALU_Src,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic [1:0]             pc_src,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   illegal,
    output logic                   mem_fault,
    output logic [COUNT_WIDTH-1:0] retired
);

    // Stage encoding doubles as the visible stage number.
    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EX  = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    localparam logic [1:0] ALUOP_RTYPE  = 2'b00;
    localparam logic [1:0] ALUOP_ADD    = 2'b11;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT);
    localparam logic [3:0] WAIT_ONE   = 4'd1;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    // ALU operation class for an opcode; anything without an ALU role gets R.
    function automatic logic [1:0] alu_op_of(input logic [5:0] op);
        logic [1:0] res;
        case (op)
            OP_ADDI, OP_LW, OP_SW: res = ALUOP_ADD;
            OP_BEQ, OP_BNE:        res = ALUOP_BRANCH;
            default:               res = ALUOP_RTYPE;
        endcase
        return res;
    endfunction

    // True for the seven opcodes this sequencer understands.
    function automatic logic is_legal_op(input logic [5:0] op);
        logic res;
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J: res = 1'b1;
            default:              res = 1'b0;
        endcase
        return res;
    endfunction

    logic [2:0]             stage_r;
    logic [2:0]             stage_nxt_s;
    logic [31:0]            ir_r;
    logic [3:0]             wait_cnt_r;
    logic [3:0]             wait_nxt_s;
    logic [COUNT_WIDTH-1:0] retired_r;

    logic [5:0] opcode_s;
    logic       is_r_s;
    logic       is_addi_s;
    logic       is_lw_s;
    logic       is_sw_s;
    logic       is_beq_s;
    logic       is_bne_s;
    logic       is_j_s;
    logic       is_legal_s;
    logic       is_mem_s;
    logic       taken_s;
    logic       timeout_s;
    logic       retire_s;
    logic       ir_unused_s;

    assign opcode_s   = ir_r[31:26];
    assign is_r_s     = (opcode_s == OP_RTYPE);
    assign is_addi_s  = (opcode_s == OP_ADDI);
    assign is_lw_s    = (opcode_s == OP_LW);
    assign is_sw_s    = (opcode_s == OP_SW);
    assign is_beq_s   = (opcode_s == OP_BEQ);
    assign is_bne_s   = (opcode_s == OP_BNE);
    assign is_j_s     = (opcode_s == OP_J);
    assign is_legal_s = is_legal_op(opcode_s);
    assign is_mem_s   = is_lw_s | is_sw_s;

    // Register/immediate fields are consumed by the datapath, not here.
    assign ir_unused_s = ^ir_r[25:6];

    assign taken_s   = (is_beq_s & zero) | (is_bne_s & ~zero);
    // A ready arriving in the limit cycle still completes the access.
    assign timeout_s = (wait_cnt_r == WAIT_LIMIT) & ~mem_ready;

    // Next-stage selection for the decoded instruction class.
    always_comb begin
        stage_nxt_s = ST_IF;
        case (stage_r)
            ST_IF: begin
                stage_nxt_s = ST_ID;
            end
            ST_ID: begin
                if (is_j_s || !is_legal_s) begin
                    stage_nxt_s = ST_IF;
                end else begin
                    stage_nxt_s = ST_EX;
                end
            end
            ST_EX: begin
                if (is_r_s || is_addi_s) begin
                    stage_nxt_s = ST_WB;
                end else if (is_mem_s || is_beq_s || is_bne_s) begin
                    stage_nxt_s = ST_MEM;
                end else begin
                    stage_nxt_s = ST_IF;
                end
            end
            ST_MEM: begin
                if (is_mem_s && mem_ready) begin
                    stage_nxt_s = is_lw_s ? ST_WB : ST_IF;
                end else if (is_mem_s && !timeout_s) begin
                    stage_nxt_s = ST_MEM;
                end else begin
                    stage_nxt_s = ST_IF;
                end
            end
            ST_WB: begin
                stage_nxt_s = ST_IF;
            end
            default: begin
                stage_nxt_s = ST_IF;
            end
        endcase
    end

    // Wait counter counts non-ready MEM cycles and clears on any exit.
    always_comb begin
        wait_nxt_s = 4'd0;
        if ((stage_r == ST_MEM) && is_mem_s && !mem_ready && !timeout_s) begin
            wait_nxt_s = wait_cnt_r + WAIT_ONE;
        end else begin
            wait_nxt_s = 4'd0;
        end
    end

    // Last cycle of every legal instruction that was not faulted.
    always_comb begin
        retire_s = 1'b0;
        case (stage_r)
            ST_ID:   retire_s = is_j_s;
            ST_MEM:  retire_s = is_beq_s | is_bne_s | (is_sw_s & mem_ready);
            ST_WB:   retire_s = 1'b1;
            default: retire_s = 1'b0;
        endcase
    end

    // Stage, instruction register and wait counter state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_r    <= ST_IF;
            ir_r       <= 32'd0;
            wait_cnt_r <= 4'd0;
        end else begin
            stage_r    <= stage_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            if (stage_r == ST_IF) begin
                ir_r <= instr;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Saturating count of retired instructions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_r <= {COUNT_WIDTH{1'b0}};
        end else if (retire_s && (retired_r != CNT_MAX)) begin
            retired_r <= retired_r + CNT_ONE;
        end else begin
            retired_r <= retired_r;
        end
    end

    // ALU control word, held from IR so the ALU sees it stable in stages 1-4.
    always_comb begin
        alu_op    = alu_op_of(opcode_s);
        ALU_Src   = is_addi_s | is_mem_s;
        alu_funct = FUNCT_ADD;
        if (is_r_s && reset_n) begin
            alu_funct = ir_r[5:0];
        end else begin
            alu_funct = FUNCT_ADD;
        end
    end

    // Per-stage strobes, all forced low while reset is held.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_SEQ;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        mem_fault  = 1'b0;
        if (reset_n) begin
            case (stage_r)
                ST_IF: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PCSRC_SEQ;
                end
                ST_ID: begin
                    if (is_j_s) begin
                        pc_write = 1'b1;
                        pc_src   = PCSRC_JUMP;
                    end else begin
                        illegal = ~is_legal_s;
                    end
                end
                ST_EX: begin
                    pc_write = 1'b0;
                end
                ST_MEM: begin
                    if ((is_beq_s || is_bne_s) && taken_s) begin
                        pc_write = 1'b1;
                        pc_src   = PCSRC_BRANCH;
                    end else begin
                        pc_write = 1'b0;
                    end
                    mem_read  = is_lw_s & ~timeout_s;
                    mem_write = is_sw_s & ~timeout_s;
                    mem_fault = is_mem_s & timeout_s;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_r_s;
                    mem_to_reg = is_lw_s;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end else begin
            ir_write = 1'b0;
        end
    end

    assign stage   = stage_r;
    assign retired = retired_r;

endmodule
